// File: rtl/sdr_ft_pkg.sv
// Definitions shared by the FTDI transmit mux and the receive demux, so that both
// directions build and parse exactly the same packet header.
package sdr_ft_pkg;

  localparam int FT_DATA_WIDTH = 32;

  // Packet mode carried in the header mode bit
  localparam logic TOFIFO = 1'b0;
  localparam logic TOCPU  = 1'b1;

  localparam int HDR_MODE_BIT    = 31;
  localparam int HDR_IQ_LEN_LSB  = 0;
  localparam int HDR_IQ_LEN_W    = 16;
  localparam int HDR_CPU_LEN_LSB = 20;
  localparam int HDR_CPU_LEN_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY
  } a2f_state_e;

  function automatic logic [FT_DATA_WIDTH-1:0] iq_header(input logic [HDR_IQ_LEN_W-1:0] len);
    logic [FT_DATA_WIDTH-1:0] hdr;
    hdr = '0;
    hdr[HDR_MODE_BIT] = TOFIFO;
    hdr[HDR_IQ_LEN_LSB +: HDR_IQ_LEN_W] = len;
    return hdr;
  endfunction

  function automatic logic [FT_DATA_WIDTH-1:0] cpu_header(input logic [HDR_CPU_LEN_W-1:0] len);
    logic [FT_DATA_WIDTH-1:0] hdr;
    hdr = '0;
    hdr[HDR_MODE_BIT] = TOCPU;
    hdr[HDR_CPU_LEN_LSB +: HDR_CPU_LEN_W] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/sel_a2f_if.sv
// FTDI write bus: a registered data word with its valid strobe, and the TX-full
// back-pressure that comes back from the FTDI side.
interface sel_a2f_if #(
  parameter int W = 32
);
  logic [W-1:0] data;
  logic         we;
  logic         full;

  modport master (output data, output we, input full);
  modport slave  (input data, input we, output full);
endinterface

// File: rtl/sel_a2f_ft_out_reg.sv
// Output register toward the FTDI. It loads whenever its slot is free: either it
// holds no valid word, or the word it holds is being accepted this cycle.
module ft_out_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  output logic         o_slot_free,
  sel_a2f_if.master    ft
);

  assign o_slot_free = ~ft.we | ~ft.full;

  // NOTE: data is not cleared when no word loads; we alone qualifies it, which
  // keeps the wide register off the per-cycle enable path.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      ft.data <= '0;
      ft.we   <= 1'b0;
    end else if (o_slot_free) begin
      ft.we <= i_load;
      if (i_load) begin
        ft.data <= i_load_data;
      end
    end
  end

endmodule

// File: rtl/sel_a2f.sv
// Transmit-side FTDI mux: round-robin arbitration between the IQ sample FIFO and
// the ECPU response queue, framing each grant as one header word plus its payload.
module sel_a2f #(
  parameter int FT_DATA_WIDTH    = sdr_ft_pkg::FT_DATA_WIDTH,
  parameter int IQ_PAIR_WIDTH    = 24,
  parameter int QSTART_BIT_INDEX = 16,
  parameter int BURST_LEN        = 256
) (
  input  logic                     clk_i,
  input  logic                     reset_n,
  input  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i,
  input  logic                     fifo_empty_i,
  input  logic                     fifo_enough_i,
  output logic                     fifo_re_o,
  input  logic                     cpu_req_i,
  input  logic [7:0]               cpu_len_i,
  output logic                     cpu_ack_o,
  input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
  input  logic                     cpu_empty_i,
  output logic                     cpu_re_o,
  output logic [FT_DATA_WIDTH-1:0] data_o,
  output logic                     we_o,
  input  logic                     full_i,
  output logic                     busy_o
);
  import sdr_ft_pkg::*;

  localparam int          HALF         = IQ_PAIR_WIDTH / 2;
  localparam logic [15:0] LP_BURST_LEN = 16'(BURST_LEN);

  a2f_state_e r_state;
  logic       r_mode;
  logic       r_last_grant;
  logic       r_cpu_ack;
  logic [15:0] r_len;
  logic [15:0] r_cnt;

  logic       w_slot_free;
  logic       w_hdr_load;
  logic       w_pay_load;
  logic       w_load;
  logic       w_src_empty;
  logic       w_cpu_cand;
  logic       w_iq_cand;
  logic       w_grant_valid;
  logic       w_grant_mode;
  logic [15:0] w_cnt_nxt;
  logic [HALF-1:0] w_q;
  logic [HALF-1:0] w_i;
  logic [FT_DATA_WIDTH-1:0] w_iq_word;
  logic [FT_DATA_WIDTH-1:0] w_hdr_word;
  logic [FT_DATA_WIDTH-1:0] w_load_data;

  sel_a2f_if #(.W(FT_DATA_WIDTH)) u_ft_bus ();

  assign u_ft_bus.full = full_i;
  assign data_o        = u_ft_bus.data;
  assign we_o          = u_ft_bus.we;

  ft_out_reg #(.W(FT_DATA_WIDTH)) u_out_reg (
    .clk_i       (clk_i),
    .reset_n     (reset_n),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .o_slot_free (w_slot_free),
    .ft          (u_ft_bus.master)
  );

  // A CPU request is still visible during the ack cycle; masking it there stops a
  // zero-length response from being granted twice.
  assign w_cpu_cand = cpu_req_i & ~r_cpu_ack;
  assign w_iq_cand  = fifo_enough_i;

  always_comb begin
    w_grant_valid = w_cpu_cand | w_iq_cand;
    w_grant_mode  = TOFIFO;
    if (w_cpu_cand && w_iq_cand) begin
      w_grant_mode = ~r_last_grant;
    end else if (w_cpu_cand) begin
      w_grant_mode = TOCPU;
    end
  end

  assign w_src_empty = (r_mode == TOCPU) ? cpu_empty_i : fifo_empty_i;
  assign w_hdr_load  = (r_state == ST_HDR) & w_slot_free;
  assign w_pay_load  = (r_state == ST_PAY) & w_slot_free & ~w_src_empty;
  assign w_load      = w_hdr_load | w_pay_load;
  assign w_cnt_nxt   = r_cnt + 16'd1;

  assign fifo_re_o = w_pay_load & (r_mode == TOFIFO);
  assign cpu_re_o  = w_pay_load & (r_mode == TOCPU);
  assign cpu_ack_o = r_cpu_ack;
  assign busy_o    = (r_state != ST_IDLE);

  // Q and I are each sign-extended into their own half of the FTDI word
  assign w_q = fifo_data_i[IQ_PAIR_WIDTH-1:HALF];
  assign w_i = fifo_data_i[HALF-1:0];
  assign w_iq_word = {{(FT_DATA_WIDTH-QSTART_BIT_INDEX-HALF){w_q[HALF-1]}}, w_q,
                      {(QSTART_BIT_INDEX-HALF){w_i[HALF-1]}}, w_i};

  assign w_hdr_word = (r_mode == TOCPU) ? cpu_header(r_len[7:0]) : iq_header(LP_BURST_LEN);

  always_comb begin
    w_load_data = w_iq_word;
    if (w_hdr_load) begin
      w_load_data = w_hdr_word;
    end else if (r_mode == TOCPU) begin
      w_load_data = cpu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_mode       <= TOFIFO;
      r_len        <= '0;
      r_cnt        <= '0;
      r_last_grant <= TOCPU;
      r_cpu_ack    <= 1'b0;
    end else begin
      // NOTE: the ack defaults low every cycle, so it can only be a one-cycle pulse.
      r_cpu_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_mode  <= w_grant_mode;
            r_len   <= (w_grant_mode == TOCPU) ? {8'h00, cpu_len_i} : LP_BURST_LEN;
            r_cnt   <= '0;
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_slot_free) begin
            r_cpu_ack    <= (r_mode == TOCPU);
            r_last_grant <= r_mode;
            r_state      <= (r_len == 16'd0) ? ST_IDLE : ST_PAY;
          end
        end
        ST_PAY: begin
          if (w_pay_load) begin
            if (w_cnt_nxt == r_len) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sel_a2f.sv
// Directed bench for sel_a2f with BURST_LEN=4: queue models for both sources and
// a transfer log of every word accepted on the FTDI side.
module tb_sel_a2f;

  localparam int BL = 4;

  logic        clk_i = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] fifo_data_i;
  logic        fifo_empty_i;
  logic        fifo_enough_i;
  logic        fifo_re_o;
  logic        cpu_req_i;
  logic [7:0]  cpu_len_i;
  logic        cpu_ack_o;
  logic [31:0] cpu_data_i;
  logic        cpu_empty_i;
  logic        cpu_re_o;
  logic        busy_o;

  sel_a2f_if #(.W(32)) ft ();

  sel_a2f #(.BURST_LEN(BL)) dut (
    .clk_i         (clk_i),
    .reset_n       (reset_n),
    .fifo_data_i   (fifo_data_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_enough_i (fifo_enough_i),
    .fifo_re_o     (fifo_re_o),
    .cpu_req_i     (cpu_req_i),
    .cpu_len_i     (cpu_len_i),
    .cpu_ack_o     (cpu_ack_o),
    .cpu_data_i    (cpu_data_i),
    .cpu_empty_i   (cpu_empty_i),
    .cpu_re_o      (cpu_re_o),
    .data_o        (ft.data),
    .we_o          (ft.we),
    .full_i        (ft.full),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic        ack;
    int          cyc;
  } xfer_t;

  typedef struct {
    logic [11:0] q;
    logic [11:0] i;
    logic [31:0] exp;
  } iq_vec_t;

  iq_vec_t     vecs [4];
  logic [23:0] iq_q [$];
  logic [31:0] cpu_q [$];
  xfer_t       got [$];
  logic [31:0] expw [$];
  int cyc, total, bad, iq_pops, cpu_pops, ack_cnt, start;
  logic force_enough;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_sources();
    fifo_empty_i  = (iq_q.size() == 0);
    fifo_enough_i = force_enough || (iq_q.size() >= BL);
    if (iq_q.size() > 0) fifo_data_i = iq_q[0];
    else                 fifo_data_i = '0;
    cpu_empty_i = (cpu_q.size() == 0);
    if (cpu_q.size() > 0) cpu_data_i = cpu_q[0];
    else                  cpu_data_i = '0;
  endtask

  // One clock: sample mid-cycle, then retire pops after the edge
  task automatic tick();
    logic p_iq, p_cpu, ack;
    #1;
    p_iq  = fifo_re_o;
    p_cpu = cpu_re_o;
    ack   = cpu_ack_o;
    if (ft.we && !ft.full) got.push_back('{d: ft.data, ack: ack, cyc: cyc});
    if (ack) ack_cnt++;
    @(posedge clk_i);
    #1;
    if (p_iq && iq_q.size() > 0) begin
      void'(iq_q.pop_front());
      iq_pops++;
    end
    if (p_cpu && cpu_q.size() > 0) begin
      void'(cpu_q.pop_front());
      cpu_pops++;
    end
    if (ack) cpu_req_i = 1'b0;
    drive_sources();
    cyc++;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int k = 0; k < budget && got.size() < n; k++) tick();
    check($sformatf("word_count_%0d", n), 32'(got.size()), 32'(n));
  endtask

  task automatic clear_log();
    got.delete();
    iq_pops  = 0;
    cpu_pops = 0;
    ack_cnt  = 0;
  endtask

  task automatic push_vecs();
    for (int k = 0; k < 4; k++) iq_q.push_back({vecs[k].q, vecs[k].i});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    iq_q.delete();
    cpu_q.delete();
    clear_log();
    cpu_req_i    = 1'b0;
    cpu_len_i    = 8'd0;
    force_enough = 1'b0;
    ft.full      = 1'b0;
    drive_sources();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic compare_log(input string tag);
    for (int k = 0; k < expw.size(); k++) begin
      check($sformatf("%s_w%0d", tag, k), got[k].d, expw[k]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{q: 12'h800, i: 12'h7FF, exp: 32'hF80007FF};
    vecs[1] = '{q: 12'h7FF, i: 12'h800, exp: 32'h07FFF800};
    vecs[2] = '{q: 12'h123, i: 12'h456, exp: 32'h01230456};
    vecs[3] = '{q: 12'hFFF, i: 12'hFFF, exp: 32'hFFFFFFFF};
    total = 0;
    bad   = 0;
    cyc   = 0;

    do_reset();
    check("rst_we", 32'(ft.we), 32'd0);
    check("rst_data", ft.data, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ack", 32'(cpu_ack_o), 32'd0);
    check("rst_fifo_re", 32'(fifo_re_o), 32'd0);
    check("rst_cpu_re", 32'(cpu_re_o), 32'd0);

    // IQ-only packet: header, packing table, pop count, grant latency
    push_vecs();
    drive_sources();
    start = cyc;
    wait_words(5, 40);
    check("iq_hdr", got[0].d, 32'h00000004);
    check("iq_hdr_latency", 32'(got[0].cyc - start), 32'd2);
    for (int k = 0; k < 4; k++) check($sformatf("iq_pack%0d", k), got[k+1].d, vecs[k].exp);
    repeat (4) tick();
    check("iq_pops", 32'(iq_pops), 32'd4);
    check("iq_idle", 32'(busy_o), 32'd0);
    check("iq_no_extra", 32'(got.size()), 32'd5);

    // CPU-only packet of three words
    clear_log();
    cpu_q.push_back(32'hAAAA0001);
    cpu_q.push_back(32'hBBBB0002);
    cpu_q.push_back(32'hCCCC0003);
    cpu_len_i = 8'd3;
    cpu_req_i = 1'b1;
    drive_sources();
    wait_words(4, 40);
    expw = '{32'h80300000, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    compare_log("cpu");
    check("cpu_ack_with_hdr", 32'(got[0].ack), 32'd1);
    repeat (4) tick();
    check("cpu_ack_count", 32'(ack_cnt), 32'd1);
    check("cpu_pops", 32'(cpu_pops), 32'd3);
    check("cpu_idle", 32'(busy_o), 32'd0);

    // Both pending from reset: IQ, then CPU, then IQ again
    do_reset();
    push_vecs();
    push_vecs();
    cpu_q.push_back(32'h12345678);
    cpu_q.push_back(32'h9ABCDEF0);
    cpu_len_i = 8'd2;
    cpu_req_i = 1'b1;
    drive_sources();
    wait_words(13, 80);
    expw = '{32'h00000004, vecs[0].exp, vecs[1].exp, vecs[2].exp, vecs[3].exp,
             32'h80200000, 32'h12345678, 32'h9ABCDEF0,
             32'h00000004, vecs[0].exp, vecs[1].exp, vecs[2].exp, vecs[3].exp};
    compare_log("rr");
    check("rr_cpu_ack", 32'(got[5].ack), 32'd1);
    check("rr_gap", 32'(got[5].cyc - got[4].cyc), 32'd2);

    // Back-pressure for five cycles mid-payload
    repeat (3) tick();
    clear_log();
    push_vecs();
    drive_sources();
    wait_words(2, 40);
    ft.full = 1'b1;
    repeat (5) begin
      tick();
      check("stall_data", ft.data, vecs[1].exp);
      check("stall_we", 32'(ft.we), 32'd1);
    end
    check("stall_pops", 32'(iq_pops), 32'd2);
    ft.full = 1'b0;
    wait_words(5, 40);
    expw = '{32'h00000004, vecs[0].exp, vecs[1].exp, vecs[2].exp, vecs[3].exp};
    compare_log("stall");
    repeat (3) tick();
    check("stall_total_pops", 32'(iq_pops), 32'd4);
    check("stall_no_dup", 32'(got.size()), 32'd5);

    // Zero-length CPU response: header only, queue untouched
    clear_log();
    cpu_q.push_back(32'h5A5A5A5A);
    cpu_len_i = 8'd0;
    cpu_req_i = 1'b1;
    drive_sources();
    repeat (12) tick();
    check("len0_words", 32'(got.size()), 32'd1);
    check("len0_hdr", got[0].d, 32'h80000000);
    check("len0_ack", 32'(ack_cnt), 32'd1);
    check("len0_pops", 32'(cpu_pops), 32'd0);
    check("len0_queue", 32'(cpu_q.size()), 32'd1);
    check("len0_idle", 32'(busy_o), 32'd0);
    cpu_q.delete();
    drive_sources();

    // FIFO underrun mid-packet: stall, then finish on refill
    clear_log();
    force_enough = 1'b1;
    iq_q.push_back({vecs[0].q, vecs[0].i});
    iq_q.push_back({vecs[1].q, vecs[1].i});
    drive_sources();
    wait_words(1, 20);
    force_enough = 1'b0;
    drive_sources();
    wait_words(3, 20);
    repeat (5) tick();
    check("under_words", 32'(got.size()), 32'd3);
    check("under_we", 32'(ft.we), 32'd0);
    check("under_busy", 32'(busy_o), 32'd1);
    iq_q.push_back({vecs[2].q, vecs[2].i});
    iq_q.push_back({vecs[3].q, vecs[3].i});
    drive_sources();
    wait_words(5, 20);
    compare_log("under");
    repeat (3) tick();
    check("under_idle", 32'(busy_o), 32'd0);

    // Reset in the middle of a payload
    clear_log();
    push_vecs();
    drive_sources();
    wait_words(3, 30);
    reset_n = 1'b0;
    #1;
    check("mrst_we", 32'(ft.we), 32'd0);
    check("mrst_data", ft.data, 32'd0);
    check("mrst_busy", 32'(busy_o), 32'd0);
    check("mrst_fifo_re", 32'(fifo_re_o), 32'd0);
    iq_q.delete();
    clear_log();
    drive_sources();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n = 1'b1;
    iq_q.push_back({vecs[3].q, vecs[3].i});
    iq_q.push_back({vecs[2].q, vecs[2].i});
    iq_q.push_back({vecs[1].q, vecs[1].i});
    iq_q.push_back({vecs[0].q, vecs[0].i});
    drive_sources();
    wait_words(5, 40);
    expw = '{32'h00000004, vecs[3].exp, vecs[2].exp, vecs[1].exp, vecs[0].exp};
    compare_log("mrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sel_a2f.md
Name: sel_a2f

Overview:
- Transmit-side counterpart of the FTDI receive demux. It arbitrates between the ADC IQ sample FIFO and the ECPU response path, and frames their data into header-plus-payload packets on the 32-bit FTDI write interface.
- The header format matches the one the host-to-board demux decodes, so the host parses both directions with one parser.

Parameters:
- FT_DATA_WIDTH, 32: FTDI word width.
- IQ_PAIR_WIDTH, 24: I/Q pair width from FIFO, Q in upper half.
- QSTART_BIT_INDEX, 16: bit position of Q in an FTDI word.
- BURST_LEN, 256: IQ payload words per packet, range 1..65535.

Ports:
- clk_i  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_data_i  in  24  IQ pair, first-word-fall-through; bits [23:12] are Q, bits [11:0] are I.
- fifo_empty_i  in  1  IQ FIFO empty.
- fifo_enough_i  in  1  IQ FIFO holds at least BURST_LEN pairs.
- fifo_re_o  out  1  pop the IQ FIFO.
- cpu_req_i  in  1  CPU response pending; level, held until cpu_ack_o.
- cpu_len_i  in  8  CPU payload word count; stable while cpu_req_i is high.
- cpu_ack_o  out  1  one-cycle pulse when the CPU header is loaded.
- cpu_data_i  in  32  CPU word, first-word-fall-through.
- cpu_empty_i  in  1  CPU queue empty.
- cpu_re_o  out  1  pop the CPU queue.
- data_o  out  32  word to FTDI.
- we_o  out  1  data_o valid.
- full_i  in  1  FTDI TX full.
- busy_o  out  1  packet in progress (state != IDLE).

Behaviour:
- Reset values (asynchronous assert, synchronous release): state=IDLE, data_o=0, we_o=0, cpu_ack_o=0, payload counter=0, last_grant=CPU. fifo_re_o and cpu_re_o are combinational and 0 while in IDLE.
- Output register and handshake:
  - data_o/we_o form one output register.
  - A word transfers in a cycle where we_o=1 and full_i=0.
  - If full_i=1, data_o and we_o hold unchanged.
  - slot_free = ~we_o | ~full_i. The register loads only when slot_free is high. If slot_free is high and nothing loads, we_o goes to 0 on the next edge.
- State machine states: IDLE, HDR, PAY.
- IDLE transitions:
  - Candidates: CPU if cpu_req_i=1; IQ if fifo_enough_i=1.
  - If both are candidates, grant the source opposite to last_grant (round robin).
  - On grant, latch mode (0=IQ, 1=CPU) and length (BURST_LEN, or cpu_len_i zero-extended), then go to HDR.
  - Granting costs one cycle, so a header appears no earlier than 2 cycles after the request.
- HDR: when slot_free, load the header, set we_o=1, and go to PAY. If length=0, go to IDLE instead. For CPU mode, pulse cpu_ack_o in the same cycle as the header load. Set last_grant=mode.
  - IQ header: bit31=0, bits[30:16]=0, bits[15:0]=BURST_LEN.
  - CPU header: bit31=1, bits[30:28]=0, bits[27:20]=len, bits[19:0]=0.
- PAY, source handling:
  - Load when slot_free and the selected source is not empty.
  - The pop strobe (fifo_re_o or cpu_re_o) equals that load condition, is combinational, and is gated by mode.
  - IQ payload word: bits[27:16]=Q, bits[11:0]=I; bits[31:28] are the sign extension of Q[11]; bits[15:12] are the sign extension of I[11].
  - CPU payload word: cpu_data_i passed through.
- PAY, counting: the counter increments on each load. When the load of word number `length` occurs, clear the counter and go to IDLE. The next grant is evaluated in IDLE the following cycle.
- Source underrun mid-payload: stall with no padding; we_o drops once the last word has drained. The packet stays open indefinitely.
- Source changes while in PAY: fifo_enough_i and cpu_req_i are ignored. A CPU request cannot pre-empt an IQ packet.
- cpu_len_i=0: header only; the CPU queue is not popped.
- Reset mid-packet: the partial packet is abandoned and outputs return to reset values. The host resynchronises on the next header.
- Throughput: one word per cycle while full_i=0 and the source is non-empty. Per-packet overhead is one header word plus one IDLE cycle.

Decomposition:
- Shared package sdr_ft_pkg, also used by the receive demux:
  - mode constants TOFIFO=1'b0 and TOCPU=1'b1;
  - header bit positions: mode bit 31, IQ length [15:0], CPU length [27:20];
  - FT_DATA_WIDTH default.
- One natural sub-module, ft_out_reg: the output register with its slot_free/hold logic. Arbitration, FSM and packing stay in sel_a2f.

Test Plan:
- IQ only, BURST_LEN=4, full_i=0, fifo_enough_i=1, pairs Q=0x800 / I=0x7FF and similar:
  - the header is 0x00000004;
  - the first payload word is 0xF8000 7FF as one 32-bit value (0xF80007FF);
  - exactly 4 pops occur, then the block returns to IDLE.
- CPU only, cpu_len_i=3, data A/B/C:
  - the header is 0x80300000 and cpu_ack_o pulses once in the same cycle;
  - A, B, C follow with 3 cpu_re_o pulses.
- Both sources pending from reset:
  - IQ is granted first (last_grant=CPU);
  - the CPU packet follows immediately after, and packets then alternate.
- full_i high for 5 cycles mid-payload: data_o and we_o are held stable, there are no pops, and no word is lost or duplicated.
- cpu_len_i=0: only 0x80000000 is emitted and cpu_re_o never asserts. Separately, fifo_empty_i high mid-IQ-packet: the packet stalls, then completes correctly when the FIFO refills.
- reset_n low mid-payload: we_o=0 immediately, state is IDLE, and the next packet begins with a correct header.
